core_if_branch_predict: RTL and testbench

//  Fetch-stage PC generator with dynamic branch prediction; the IF-stage consumer of the EX branch-judge result.

---
 rtl/core_bpu_pkg.sv | 38 +++
 rtl/core_if_branch_predict_if.sv | 29 ++
 rtl/core_bpu_bht.sv | 52 +++++
 rtl/core_if_branch_predict.sv | 75 +++++++
 tb/tb_core_if_branch_predict.sv | 260 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/core_bpu_pkg.sv
// Shared types and helpers for the fetch-stage branch predictor:
// BHT counter states, BTB entry layout, tag extraction and counter update.
package core_bpu_pkg;

  localparam int TAG_W = 30;

  typedef enum logic [1:0] {
    SNT = 2'd0,
    WNT = 2'd1,
    WT  = 2'd2,
    ST  = 2'd3
  } bht_state_t;

  typedef struct packed {
    logic             valid;
    logic [TAG_W-1:0] tag;
    logic [31:0]      target;
  } btb_entry_t;

  // Tag is everything above the index bits, zero-extended into the fixed field
  function automatic logic [TAG_W-1:0] tag_of(logic [31:0] pc, int idx_w);
    logic [31:0] t;
    t = pc >> (idx_w + 2);
    return t[TAG_W-1:0];
  endfunction

  function automatic bht_state_t sat_update(bht_state_t s, logic taken);
    bht_state_t n;
    case (s)
      SNT:     n = taken ? WNT : SNT;
      WNT:     n = taken ? WT  : SNT;
      WT:      n = taken ? ST  : WNT;
      default: n = taken ? ST  : WT;
    endcase
    return n;
  endfunction

endpackage

// File: rtl/core_if_branch_predict_if.sv
// Fetch/predict bus between the IF-stage PC generator and the rest of the pipe.
interface core_if_branch_predict_if;
  logic        i_stall;
  logic [31:0] o_pc;
  logic        o_pred_taken;
  logic [31:0] o_pred_target;
  logic        i_id_jump;
  logic [31:0] i_id_jump_target;
  logic        i_ex_valid;
  logic [31:0] i_ex_pc;
  logic        i_ex_taken;
  logic [31:0] i_ex_target;
  logic        i_ex_pred_taken;
  logic [31:0] i_ex_pred_target;
  logic        o_flush;
  logic [31:0] o_mispred_cnt;

  modport master (
    output i_stall, i_id_jump, i_id_jump_target, i_ex_valid, i_ex_pc,
           i_ex_taken, i_ex_target, i_ex_pred_taken, i_ex_pred_target,
    input  o_pc, o_pred_taken, o_pred_target, o_flush, o_mispred_cnt
  );

  modport slave (
    input  i_stall, i_id_jump, i_id_jump_target, i_ex_valid, i_ex_pc,
           i_ex_taken, i_ex_target, i_ex_pred_taken, i_ex_pred_target,
    output o_pc, o_pred_taken, o_pred_target, o_flush, o_mispred_cnt
  );
endinterface

// File: rtl/core_bpu_bht.sv
// BHT counters plus direct-mapped BTB: one combinational read port,
// one write port landing at the clock edge (no read bypass).
module core_bpu_bht
  import core_bpu_pkg::*;
#(
  parameter int IDX_W = 6
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [IDX_W-1:0] rd_idx,
  output bht_state_t       rd_state,
  output btb_entry_t       rd_entry,
  input  logic             wr_en,
  input  logic [IDX_W-1:0] wr_idx,
  input  logic             wr_taken,
  input  logic [TAG_W-1:0] wr_tag,
  input  logic [31:0]      wr_target
);

  localparam int N = 1 << IDX_W;

  bht_state_t bht_q [N];
  bht_state_t bht_d [N];
  btb_entry_t btb_q [N];
  btb_entry_t btb_d [N];

  assign rd_state = bht_q[rd_idx];
  assign rd_entry = btb_q[rd_idx];

  // Not-taken outcomes only train the counter; the BTB keeps its last taken target
  always_comb begin
    bht_d = bht_q;
    btb_d = btb_q;
    if (wr_en) begin
      bht_d[wr_idx] = sat_update(bht_q[wr_idx], wr_taken);
      if (wr_taken) begin
        btb_d[wr_idx] = '{valid: 1'b1, tag: wr_tag, target: wr_target};
      end
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      bht_q <= '{default: WNT};
      btb_q <= '{default: '0};
    end else begin
      bht_q <= bht_d;
      btb_q <= btb_d;
    end
  end

endmodule

// File: rtl/core_if_branch_predict.sv
// Fetch-stage PC generator: predicts from BHT/BTB, trains from EX outcomes,
// redirects on EX mispredictions and ID jumps, counts mispredictions.
module core_if_branch_predict
  import core_bpu_pkg::*;
#(
  parameter logic [31:0] BOOT_ADDR = 32'h0000_0000,
  parameter int          IDX_W     = 6
) (
  input logic                     clk,
  input logic                     rst,
  core_if_branch_predict_if.slave bus
);

  logic [31:0]      pc_q, pc_d;
  logic [31:0]      cnt_q, cnt_d;
  logic [IDX_W-1:0] rd_idx, wr_idx;
  logic [TAG_W-1:0] wr_tag;
  bht_state_t       rd_state;
  btb_entry_t       rd_entry;
  logic             hit, pred_taken, mispred;
  logic [31:0]      pred_target;

  assign rd_idx = pc_q[IDX_W+1:2];
  assign wr_idx = bus.i_ex_pc[IDX_W+1:2];
  assign wr_tag = tag_of(bus.i_ex_pc, IDX_W);

  core_bpu_bht #(.IDX_W(IDX_W)) u_bht (
    .clk       (clk),
    .rst       (rst),
    .rd_idx    (rd_idx),
    .rd_state  (rd_state),
    .rd_entry  (rd_entry),
    .wr_en     (bus.i_ex_valid),
    .wr_idx    (wr_idx),
    .wr_taken  (bus.i_ex_taken),
    .wr_tag    (wr_tag),
    .wr_target (bus.i_ex_target)
  );

  // Redirects outrank stall so a killed stalled fetch still moves to the right PC
  always_comb begin
    hit         = rd_entry.valid && (rd_entry.tag == tag_of(pc_q, IDX_W));
    pred_taken  = hit && (rd_state inside {WT, ST});
    pred_target = pred_taken ? rd_entry.target : pc_q + 32'd4;
    mispred     = bus.i_ex_valid &&
                  ((bus.i_ex_taken != bus.i_ex_pred_taken) ||
                   (bus.i_ex_taken && (bus.i_ex_pred_target != bus.i_ex_target)));
    pc_d        = pred_target;
    if (mispred) begin
      pc_d = bus.i_ex_taken ? bus.i_ex_target : bus.i_ex_pc + 32'd4;
    end else if (bus.i_id_jump) begin
      pc_d = bus.i_id_jump_target;
    end else if (bus.i_stall) begin
      pc_d = pc_q;
    end
    cnt_d = mispred ? cnt_q + 32'd1 : cnt_q;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      pc_q  <= BOOT_ADDR;
      cnt_q <= '0;
    end else begin
      pc_q  <= pc_d;
      cnt_q <= cnt_d;
    end
  end

  assign bus.o_pc          = pc_q;
  assign bus.o_pred_taken  = pred_taken;
  assign bus.o_pred_target = pred_target;
  assign bus.o_flush       = mispred || bus.i_id_jump;
  assign bus.o_mispred_cnt = cnt_q;

endmodule

// File: tb/tb_core_if_branch_predict.sv
// Bench for core_if_branch_predict: directed vector table, hand sequences for
// reset/saturation/stall, and random traffic against a table-level model.
module tb_core_if_branch_predict;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   checks = 0;
  int   errors = 0;

  always #5 clk = ~clk;

  core_if_branch_predict_if bus ();

  core_if_branch_predict #(.BOOT_ADDR(32'h0), .IDX_W(6)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  typedef struct {
    bit        stall;
    bit        jump;
    bit [31:0] jt;
    bit        exv;
    bit [31:0] expc;
    bit        ext;
    bit [31:0] extg;
    bit        expt;
    bit [31:0] exptg;
  } stim_t;

  typedef struct {
    stim_t     s;
    bit [31:0] pc;
    bit        pt;
    bit [31:0] ptg;
    bit        fl;
    bit [31:0] cnt;
  } vec_t;

  // Reference model: 64 saturating counters 0..3 and a BTB keyed by index/tag
  int        m_ctr [64];
  bit        m_val [64];
  bit [31:0] m_tag [64];
  bit [31:0] m_tgt [64];
  bit [31:0] m_pc;
  bit [31:0] m_cnt;

  function automatic int idx_of(bit [31:0] pc);
    return int'((pc >> 2) & 32'h3F);
  endfunction

  function automatic void model_reset();
    for (int i = 0; i < 64; i++) begin
      m_ctr[i] = 1;
      m_val[i] = 1'b0;
      m_tag[i] = '0;
      m_tgt[i] = '0;
    end
    m_pc  = 32'h0;
    m_cnt = 32'h0;
  endfunction

  function automatic bit m_pred_taken();
    int i;
    i = idx_of(m_pc);
    return m_val[i] && (m_tag[i] == (m_pc >> 8)) && (m_ctr[i] >= 2);
  endfunction

  function automatic bit [31:0] m_pred_target();
    return m_pred_taken() ? m_tgt[idx_of(m_pc)] : m_pc + 32'd4;
  endfunction

  function automatic bit m_mispred();
    if (!bus.i_ex_valid) return 1'b0;
    if (bus.i_ex_taken != bus.i_ex_pred_taken) return 1'b1;
    return bus.i_ex_taken && (bus.i_ex_pred_target != bus.i_ex_target);
  endfunction

  function automatic void model_advance();
    bit [31:0] nxt;
    int        i;
    if (m_mispred()) begin
      nxt   = bus.i_ex_taken ? bus.i_ex_target : bus.i_ex_pc + 32'd4;
      m_cnt = m_cnt + 32'd1;
    end else if (bus.i_id_jump) nxt = bus.i_id_jump_target;
    else if (bus.i_stall)       nxt = m_pc;
    else                        nxt = m_pred_target();
    if (bus.i_ex_valid) begin
      i = idx_of(bus.i_ex_pc);
      if (bus.i_ex_taken) begin
        if (m_ctr[i] < 3) m_ctr[i]++;
        m_val[i] = 1'b1;
        m_tag[i] = bus.i_ex_pc >> 8;
        m_tgt[i] = bus.i_ex_target;
      end else if (m_ctr[i] > 0) begin
        m_ctr[i]--;
      end
    end
    m_pc = nxt;
  endfunction

  task automatic check_val(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("[TB] FAIL %s actual=0x%08h expected=0x%08h", name, act, exp);
    end
  endtask

  task automatic apply_stimulus(input stim_t s);
    bus.i_stall          = s.stall;
    bus.i_id_jump        = s.jump;
    bus.i_id_jump_target = s.jt;
    bus.i_ex_valid       = s.exv;
    bus.i_ex_pc          = s.expc;
    bus.i_ex_taken       = s.ext;
    bus.i_ex_target      = s.extg;
    bus.i_ex_pred_taken  = s.expt;
    bus.i_ex_pred_target = s.exptg;
  endtask

  task automatic check_output();
    check_val("model_pc", bus.o_pc, m_pc);
    check_val("model_pred_taken", {31'b0, bus.o_pred_taken}, {31'b0, m_pred_taken()});
    check_val("model_pred_target", bus.o_pred_target, m_pred_target());
    check_val("model_flush", {31'b0, bus.o_flush}, {31'b0, (m_mispred() | bus.i_id_jump)});
    check_val("model_mispred_cnt", bus.o_mispred_cnt, m_cnt);
  endtask

  // Inputs change just after the falling edge; checks and model update bracket the rising edge
  task automatic step(input stim_t s);
    apply_stimulus(s);
    #1;
    check_output();
    @(posedge clk);
    model_advance();
    @(negedge clk);
  endtask

  function automatic stim_t mk(bit stall, bit jump, bit [31:0] jt, bit exv, bit [31:0] expc,
                               bit ext, bit [31:0] extg, bit expt, bit [31:0] exptg);
    stim_t s;
    s.stall = stall; s.jump = jump; s.jt = jt;
    s.exv = exv; s.expc = expc; s.ext = ext; s.extg = extg;
    s.expt = expt; s.exptg = exptg;
    return s;
  endfunction

  function automatic bit [31:0] pick_pc();
    bit [31:0] base;
    if ($urandom_range(0, 15) == 0) return 32'hFFFF_FFFC;
    base = ($urandom_range(0, 3) == 0) ? 32'h100 : 32'h0;
    return base + 32'($urandom_range(0, 31)) * 32'd4;
  endfunction

  vec_t  vecs [14];
  stim_t idle;
  stim_t s;
  bit [31:0] held_pc;
  bit        exp_pt [4];

  initial begin
    idle = mk(0, 0, 0, 0, 0, 0, 0, 0, 0);
    vecs[0]  = '{idle,                                                    32'h0,   0, 32'h4,   0, 0};
    vecs[1]  = '{mk(0, 0, 0, 1, 32'h40, 1, 32'h20, 0, 32'h44),             32'h4,   0, 32'h8,   1, 0};
    vecs[2]  = '{mk(0, 0, 0, 1, 32'h40, 1, 32'h20, 0, 32'h44),             32'h20,  0, 32'h24,  1, 1};
    vecs[3]  = '{mk(0, 1, 32'h40, 0, 0, 0, 0, 0, 0),                       32'h20,  0, 32'h24,  1, 2};
    vecs[4]  = '{idle,                                                    32'h40,  1, 32'h20,  0, 2};
    vecs[5]  = '{mk(0, 1, 32'h140, 0, 0, 0, 0, 0, 0),                      32'h20,  0, 32'h24,  1, 2};
    vecs[6]  = '{idle,                                                    32'h140, 0, 32'h144, 0, 2};
    vecs[7]  = '{mk(1, 1, 32'h200, 1, 32'h60, 1, 32'h80, 0, 32'h64),       32'h144, 0, 32'h148, 1, 2};
    vecs[8]  = '{mk(1, 0, 0, 0, 0, 0, 0, 0, 0),                            32'h80,  0, 32'h84,  0, 3};
    vecs[9]  = '{mk(0, 0, 0, 1, 32'h40, 1, 32'h20, 1, 32'h20),             32'h80,  0, 32'h84,  0, 3};
    vecs[10] = '{mk(0, 0, 0, 1, 32'h40, 1, 32'h20, 1, 32'h24),             32'h84,  0, 32'h88,  1, 3};
    vecs[11] = '{mk(0, 1, 32'hFFFF_FFFC, 0, 0, 0, 0, 0, 0),                32'h20,  0, 32'h24,  1, 4};
    vecs[12] = '{idle,                                                    32'hFFFF_FFFC, 0, 32'h0, 0, 4};
    vecs[13] = '{idle,                                                    32'h0,   0, 32'h4,   0, 4};

    apply_stimulus(idle);
    @(negedge clk);
    @(negedge clk);
    check_val("reset_pc", bus.o_pc, 32'h0);
    check_val("reset_cnt", bus.o_mispred_cnt, 32'h0);
    check_val("reset_pred_taken", {31'b0, bus.o_pred_taken}, 32'h0);
    rst = 1'b0;
    model_reset();

    $display("[TB] directed vector table");
    for (int k = 0; k < 14; k++) begin
      apply_stimulus(vecs[k].s);
      #1;
      check_val($sformatf("vec%0d_pc", k), bus.o_pc, vecs[k].pc);
      check_val($sformatf("vec%0d_pred_taken", k), {31'b0, bus.o_pred_taken}, {31'b0, vecs[k].pt});
      check_val($sformatf("vec%0d_pred_target", k), bus.o_pred_target, vecs[k].ptg);
      check_val($sformatf("vec%0d_flush", k), {31'b0, bus.o_flush}, {31'b0, vecs[k].fl});
      check_val($sformatf("vec%0d_cnt", k), bus.o_mispred_cnt, vecs[k].cnt);
      step(vecs[k].s);
    end

    $display("[TB] saturating down-count at 0x40");
    step(mk(0, 1, 32'h40, 0, 0, 0, 0, 0, 0));
    exp_pt = '{1'b1, 1'b0, 1'b0, 1'b0};
    for (int k = 0; k < 4; k++) begin
      step(mk(1, 0, 0, 1, 32'h40, 0, 32'h20, 0, 32'h44));
      #1;
      check_val($sformatf("sat%0d_pred_taken", k), {31'b0, bus.o_pred_taken}, {31'b0, exp_pt[k]});
      check_val($sformatf("sat%0d_pred_target", k), bus.o_pred_target, exp_pt[k] ? 32'h20 : 32'h44);
    end

    $display("[TB] stall hold with training");
    held_pc = bus.o_pc;
    for (int k = 0; k < 5; k++) begin
      if (k < 2) step(mk(1, 0, 0, 1, 32'h300, 1, 32'h400, 1, 32'h400));
      else       step(mk(1, 0, 0, 0, 0, 0, 0, 0, 0));
      check_val($sformatf("stall%0d_pc", k), bus.o_pc, held_pc);
    end
    step(mk(0, 1, 32'h300, 0, 0, 0, 0, 0, 0));
    #1;
    check_val("stall_train_pred_taken", {31'b0, bus.o_pred_taken}, 32'h1);
    check_val("stall_train_pred_target", bus.o_pred_target, 32'h400);

    $display("[TB] random traffic");
    for (int n = 0; n < 400; n++) begin
      s.stall = ($urandom_range(0, 3) == 0);
      s.jump  = ($urandom_range(0, 9) == 0);
      s.jt    = pick_pc();
      s.exv   = ($urandom_range(0, 9) < 4);
      s.expc  = pick_pc();
      s.ext   = 1'($urandom_range(0, 1));
      s.extg  = pick_pc();
      s.expt  = 1'($urandom_range(0, 1));
      s.exptg = ($urandom_range(0, 1) == 1) ? s.extg : s.expc + 32'd4;
      step(s);
    end

    $display("[TB] mid-run reset");
    step(mk(0, 1, 32'h100, 0, 0, 0, 0, 0, 0));
    apply_stimulus(idle);
    #1;
    check_val("pre_reset_pc", bus.o_pc, 32'h100);
    #1;
    rst = 1'b1;
    #1;
    check_val("async_reset_pc", bus.o_pc, 32'h0);
    check_val("async_reset_cnt", bus.o_mispred_cnt, 32'h0);
    @(negedge clk);
    rst = 1'b0;
    model_reset();
    foreach (vecs[k]) begin
      step(mk(0, 1, 32'h40 + 32'(k) * 32'h20, 0, 0, 0, 0, 0, 0));
      #1;
      check_val($sformatf("post_reset%0d_pred_taken", k), {31'b0, bus.o_pred_taken}, 32'h0);
    end

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
